// File: rtl/pipelined_addsub.sv
// Purpose: WIDTH-bit add/subtract split into STAGES carry-chained chunks, with tag and ALU flags.
// Latency: STAGES cycles from accept to out_valid; throughput one operation per cycle.
// Backpressure: whole pipeline holds when out_valid & ~out_ready; in_ready = out_ready | ~out_valid.
module pipelined_addsub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4,
  parameter int TAG_W  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] inp1,
  input  logic [WIDTH-1:0] inp2,
  input  logic             cin,
  input  logic             sub,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             zero,
  output logic [TAG_W-1:0] tag_out
);

  localparam int CHUNK = WIDTH / STAGES;

  // Per-stage registers. Operand copies carry the not-yet-processed bits forward,
  // s_q accumulates the result bits already resolved by earlier stages.
  logic [STAGES-1:0]             v_q;
  logic [STAGES-1:0][WIDTH-1:0]  a_q;
  logic [STAGES-1:0][WIDTH-1:0]  b_q;
  logic [STAGES-1:0][WIDTH-1:0]  s_q;
  logic [STAGES-1:0]             c_q;
  logic [STAGES-1:0][TAG_W-1:0]  t_q;
  logic                          ovf_q;
  logic                          zero_q;

  // Values presented to each stage's adder (stage 0 sees conditioned inputs).
  logic [STAGES-1:0]             v_in;
  logic [STAGES-1:0][WIDTH-1:0]  a_in;
  logic [STAGES-1:0][WIDTH-1:0]  b_in;
  logic [STAGES-1:0][WIDTH-1:0]  s_in;
  logic [STAGES-1:0]             c_in;
  logic [STAGES-1:0][TAG_W-1:0]  t_in;

  // Adder results per stage.
  logic [STAGES-1:0][WIDTH-1:0]  s_nxt;
  logic [STAGES-1:0]             c_nxt;
  logic                          ch;
  logic                          cmsb;
  logic                          ovf_nxt;
  logic                          zero_nxt;

  logic                          en;

  // Single global advance: any stall at the output freezes every stage, so order is strictly FIFO.
  assign en       = out_ready | ~out_valid;
  assign in_ready = en;

  // Route inputs: stage 0 takes the conditioned operands, later stages take their predecessor.
  always_comb begin
    v_in    = '0;
    a_in    = '0;
    b_in    = '0;
    s_in    = '0;
    c_in    = '0;
    t_in    = '0;
    v_in[0] = in_valid;
    a_in[0] = inp1;
    b_in[0] = sub ? ~inp2 : inp2;
    s_in[0] = '0;
    c_in[0] = sub ? ~cin : cin;
    t_in[0] = tag_in;
    for (int k = 1; k < STAGES; k++) begin
      v_in[k] = v_q[k-1];
      a_in[k] = a_q[k-1];
      b_in[k] = b_q[k-1];
      s_in[k] = s_q[k-1];
      c_in[k] = c_q[k-1];
      t_in[k] = t_q[k-1];
    end
  end

  // Ripple-add chunk k in stage k; remember the carry entering the MSB for the overflow flag.
  always_comb begin
    s_nxt = '0;
    c_nxt = '0;
    ch    = 1'b0;
    cmsb  = 1'b0;
    for (int k = 0; k < STAGES; k++) begin
      ch       = c_in[k];
      s_nxt[k] = s_in[k];
      for (int i = 0; i < CHUNK; i++) begin
        if (k * CHUNK + i == WIDTH - 1) begin
          cmsb = ch;
        end
        s_nxt[k][k*CHUNK+i] = a_in[k][k*CHUNK+i] ^ b_in[k][k*CHUNK+i] ^ ch;
        ch = (a_in[k][k*CHUNK+i] & b_in[k][k*CHUNK+i]) |
             (ch & (a_in[k][k*CHUNK+i] ^ b_in[k][k*CHUNK+i]));
      end
      c_nxt[k] = ch;
    end
    ovf_nxt  = cmsb ^ c_nxt[STAGES-1];
    zero_nxt = ~|s_nxt[STAGES-1];
  end

  // Shift all stages together on en; bubbles only move the valid bit, data holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      s_q    <= '0;
      c_q    <= '0;
      t_q    <= '0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (en) begin
      v_q <= v_in;
      for (int k = 0; k < STAGES; k++) begin
        if (v_in[k]) begin
          a_q[k] <= a_in[k];
          b_q[k] <= b_in[k];
          s_q[k] <= s_nxt[k];
          c_q[k] <= c_nxt[k];
          t_q[k] <= t_in[k];
        end
      end
      if (v_in[STAGES-1]) begin
        ovf_q  <= ovf_nxt;
        zero_q <= zero_nxt;
      end
    end
  end

  assign out_valid = v_q[STAGES-1];
  assign sum       = s_q[STAGES-1];
  assign cout      = c_q[STAGES-1];
  assign overflow  = ovf_q;
  assign zero      = zero_q;
  assign tag_out   = t_q[STAGES-1];

endmodule
